// File: rtl/join_arb_ctrl_if.sv
// join_arb_ctrl_if: handshake and status bundle between two requesters, the arbiter and the join stage
interface join_arb_ctrl_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic          SEND_IN_A;
    logic [DW-1:0] DATA_IN_A;
    logic          ACK_IN_A;
    logic          SEND_IN_B;
    logic [DW-1:0] DATA_IN_B;
    logic          ACK_IN_B;
    logic          SEND_OUT;
    logic [DW-1:0] DATA_OUT;
    logic          ACK_OUT;
    logic          GNT_A;
    logic          GNT_B;
    logic          BUSY;
    logic [CW-1:0] CNT_A;
    logic [CW-1:0] CNT_B;
    modport master (
        output SEND_IN_A, DATA_IN_A, SEND_IN_B, DATA_IN_B, ACK_OUT,
        input  ACK_IN_A, ACK_IN_B, SEND_OUT, DATA_OUT, GNT_A, GNT_B, BUSY, CNT_A, CNT_B
    );
    modport slave (
        input  SEND_IN_A, DATA_IN_A, SEND_IN_B, DATA_IN_B, ACK_OUT,
        output ACK_IN_A, ACK_IN_B, SEND_OUT, DATA_OUT, GNT_A, GNT_B, BUSY, CNT_A, CNT_B
    );
endinterface

// File: rtl/join_arb_ctrl.sv
// join_arb_ctrl: round-robin arbiter joining two four-phase requesters onto one four-phase output
module join_arb_ctrl #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input logic          CLK,
    input logic          MR_N,
    join_arb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RTZ} state_t;
    state_t        state_q, state_d;
    logic          fav_b_q, fav_b_d;
    logic          win_b_q, win_b_d;
    logic          send_q, send_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_a_q, cnt_a_d;
    logic [CW-1:0] cnt_b_q, cnt_b_d;
    logic          pick_b;

    // Every output is a flop; reset abandons any token in flight and leaves the pointer on A
    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= IDLE;
            fav_b_q <= 1'b0;
            win_b_q <= 1'b0;
            send_q  <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            fav_b_q <= fav_b_d;
            win_b_q <= win_b_d;
            send_q  <= send_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Grant in IDLE, wait for the join ack in REQ, wait for both sides to return to zero in RTZ
    always_comb begin
        state_d = state_q;
        fav_b_d = fav_b_q;
        win_b_d = win_b_q;
        send_d  = send_q;
        ack_a_d = ack_a_q;
        ack_b_d = ack_b_q;
        gnt_a_d = gnt_a_q;
        gnt_b_d = gnt_b_q;
        data_d  = data_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        pick_b  = bus.SEND_IN_B & (~bus.SEND_IN_A | fav_b_q);
        case (state_q)
            IDLE: begin
                if (bus.SEND_IN_A | bus.SEND_IN_B) begin
                    state_d = REQ;
                    win_b_d = pick_b;
                    fav_b_d = ~pick_b;
                    send_d  = 1'b1;
                    data_d  = pick_b ? bus.DATA_IN_B : bus.DATA_IN_A;
                    ack_a_d = ~pick_b;
                    ack_b_d = pick_b;
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
                end
            end
            REQ: begin
                if (bus.ACK_OUT) begin
                    send_d  = 1'b0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!bus.ACK_OUT && !(win_b_q ? ack_b_q : ack_a_q)) begin
                    state_d = IDLE;
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    cnt_a_d = win_b_q ? cnt_a_q : cnt_a_q + 1'b1;
                    cnt_b_d = win_b_q ? cnt_b_q + 1'b1 : cnt_b_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            ack_a_d = ack_a_q & bus.SEND_IN_A;
            ack_b_d = ack_b_q & bus.SEND_IN_B;
        end
        busy_d = state_d != IDLE;
    end

    assign bus.SEND_OUT = send_q;
    assign bus.DATA_OUT = data_q;
    assign bus.ACK_IN_A = ack_a_q;
    assign bus.ACK_IN_B = ack_b_q;
    assign bus.GNT_A    = gnt_a_q;
    assign bus.GNT_B    = gnt_b_q;
    assign bus.BUSY     = busy_q;
    assign bus.CNT_A    = cnt_a_q;
    assign bus.CNT_B    = cnt_b_q;
endmodule

// File: tb/tb_join_arb_ctrl.sv
// tb_join_arb_ctrl: directed self-checking bench for the two-requester join arbiter
module tb_join_arb_ctrl;
    logic CLK = 1'b0;
    logic MR_N = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    join_arb_ctrl_if #(.DW(16), .CW(8)) bus ();
    join_arb_ctrl #(.DW(16), .CW(8)) dut (.CLK(CLK), .MR_N(MR_N), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_send"}, 32'(bus.SEND_OUT), 0);
        chk({tag, "_acka"}, 32'(bus.ACK_IN_A), 0);
        chk({tag, "_ackb"}, 32'(bus.ACK_IN_B), 0);
        chk({tag, "_gnta"}, 32'(bus.GNT_A), 0);
        chk({tag, "_gntb"}, 32'(bus.GNT_B), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_data"}, 32'(bus.DATA_OUT), 0);
        chk({tag, "_cnta"}, 32'(bus.CNT_A), 0);
        chk({tag, "_cntb"}, 32'(bus.CNT_B), 0);
    endtask

    // Called at a negedge with request(s) raised: checks the grant, then completes it with a zero-latency join stage
    task automatic serve(input string tag, input logic exp_b, input logic [15:0] exp_data);
        step();
        chk({tag, "_gnta"}, 32'(bus.GNT_A), 32'(!exp_b));
        chk({tag, "_gntb"}, 32'(bus.GNT_B), 32'(exp_b));
        chk({tag, "_send"}, 32'(bus.SEND_OUT), 1);
        chk({tag, "_data"}, 32'(bus.DATA_OUT), 32'(exp_data));
        chk({tag, "_ackloser"}, 32'(exp_b ? bus.ACK_IN_A : bus.ACK_IN_B), 0);
        if (exp_b) bus.SEND_IN_B = 1'b0;
        else bus.SEND_IN_A = 1'b0;
        bus.ACK_OUT = 1'b1;
        step();
        bus.ACK_OUT = 1'b0;
        step();
    endtask

    initial begin
        bus.SEND_IN_A = 1'b0;
        bus.SEND_IN_B = 1'b0;
        bus.DATA_IN_A = '0;
        bus.DATA_IN_B = '0;
        bus.ACK_OUT   = 1'b0;
        step();
        step();
        chk_zero("reset");
        MR_N = 1'b1;

        bus.SEND_IN_A = 1'b1;
        bus.DATA_IN_A = 16'h1234;
        step();
        chk("single_send", 32'(bus.SEND_OUT), 1);
        chk("single_data", 32'(bus.DATA_OUT), 32'h1234);
        chk("single_acka", 32'(bus.ACK_IN_A), 1);
        chk("single_gnta", 32'(bus.GNT_A), 1);
        chk("single_busy", 32'(bus.BUSY), 1);
        bus.ACK_OUT = 1'b1;
        bus.SEND_IN_A = 1'b0;
        step();
        chk("single_send_low", 32'(bus.SEND_OUT), 0);
        chk("single_acka_low", 32'(bus.ACK_IN_A), 0);
        chk("single_busy_rtz", 32'(bus.BUSY), 1);
        bus.ACK_OUT = 1'b0;
        step();
        chk("single_cnta", 32'(bus.CNT_A), 1);
        chk("single_busy_idle", 32'(bus.BUSY), 0);
        chk("single_gnta_idle", 32'(bus.GNT_A), 0);
        chk("single_data_hold", 32'(bus.DATA_OUT), 32'h1234);

        MR_N = 1'b0;
        step();
        chk("rst2_cnta", 32'(bus.CNT_A), 0);
        MR_N = 1'b1;
        bus.SEND_IN_A = 1'b1;
        bus.SEND_IN_B = 1'b1;
        bus.DATA_IN_A = 16'hAAAA;
        bus.DATA_IN_B = 16'hBBBB;
        serve("cont1a", 1'b0, 16'hAAAA);
        chk("cont1_cnta", 32'(bus.CNT_A), 1);
        chk("cont1_cntb", 32'(bus.CNT_B), 0);
        serve("cont1b", 1'b1, 16'hBBBB);
        chk("cont1_cntb2", 32'(bus.CNT_B), 1);
        bus.SEND_IN_A = 1'b1;
        bus.SEND_IN_B = 1'b1;
        bus.DATA_IN_A = 16'hA0A0;
        bus.DATA_IN_B = 16'hB0B0;
        serve("cont2a", 1'b0, 16'hA0A0);
        serve("cont2b", 1'b1, 16'hB0B0);
        chk("cont2_cnta", 32'(bus.CNT_A), 2);
        chk("cont2_cntb", 32'(bus.CNT_B), 2);

        bus.SEND_IN_A = 1'b1;
        bus.SEND_IN_B = 1'b1;
        bus.DATA_IN_A = 16'h5555;
        bus.DATA_IN_B = 16'h6666;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("slow_send", 32'(bus.SEND_OUT), 1);
            chk("slow_data", 32'(bus.DATA_OUT), 32'h5555);
            chk("slow_gntb", 32'(bus.GNT_B), 0);
            chk("slow_ackb", 32'(bus.ACK_IN_B), 0);
            step();
        end
        bus.ACK_OUT = 1'b1;
        bus.SEND_IN_A = 1'b0;
        step();
        bus.ACK_OUT = 1'b0;
        step();
        chk("slow_cnta", 32'(bus.CNT_A), 3);
        chk("slow_gntb_idle", 32'(bus.GNT_B), 0);
        serve("slow_b", 1'b1, 16'h6666);
        chk("slow_cntb", 32'(bus.CNT_B), 3);

        bus.SEND_IN_A = 1'b1;
        bus.DATA_IN_A = 16'h7777;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("hold_acka", 32'(bus.ACK_IN_A), 1);
            chk("hold_busy", 32'(bus.BUSY), 1);
            bus.ACK_OUT = (i == 0);
            step();
        end
        chk("hold_send", 32'(bus.SEND_OUT), 0);
        chk("hold_acka_last", 32'(bus.ACK_IN_A), 1);
        bus.SEND_IN_A = 1'b0;
        step();
        chk("hold_acka_drop", 32'(bus.ACK_IN_A), 0);
        chk("hold_busy_rtz", 32'(bus.BUSY), 1);
        step();
        chk("hold_busy_idle", 32'(bus.BUSY), 0);
        chk("hold_cnta", 32'(bus.CNT_A), 4);

        bus.SEND_IN_A = 1'b1;
        bus.DATA_IN_A = 16'h9999;
        step();
        step();
        chk("midrst_send_pre", 32'(bus.SEND_OUT), 1);
        #2 MR_N = 1'b0;
        #1 chk_zero("midrst");
        bus.SEND_IN_A = 1'b0;
        step();
        MR_N = 1'b1;
        bus.SEND_IN_A = 1'b1;
        bus.SEND_IN_B = 1'b1;
        bus.DATA_IN_A = 16'h4321;
        bus.DATA_IN_B = 16'h8765;
        serve("postrst_a", 1'b0, 16'h4321);
        chk("postrst_cnta", 32'(bus.CNT_A), 1);
        serve("postrst_b", 1'b1, 16'h8765);
        chk("postrst_cntb", 32'(bus.CNT_B), 1);

        MR_N = 1'b0;
        step();
        MR_N = 1'b1;
        for (int i = 0; i < 255; i++) begin
            bus.SEND_IN_A = 1'b1;
            bus.DATA_IN_A = 16'(i);
            serve("wrap", 1'b0, 16'(i));
        end
        chk("wrap_cnta_255", 32'(bus.CNT_A), 255);
        bus.SEND_IN_A = 1'b1;
        bus.DATA_IN_A = 16'hFFFF;
        serve("wrap_last", 1'b0, 16'hFFFF);
        chk("wrap_cnta_0", 32'(bus.CNT_A), 0);
        chk("wrap_cntb_0", 32'(bus.CNT_B), 0);
        chk("wrap_busy", 32'(bus.BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
